nibble_fetcher: RTL and testbench
=================================

# nibble_fetcher

Parametrised successor to the single-mode 4004 instruction fetcher. It fetches instructions of 1..MAX_WORDS words, each word 2 nibbles, from the nibble-serial ROM bus. Beyond the fixed one/two-word fetch, it adds:

- ROM wait states via `rom_valid`
- mid-fetch `abort` for branch redirect
- length-error reporting
- back-to-back fetch on acknowledge

It sits between the program counter / sequencer and the ROM port, and hands assembled instructions to the decoder.

## Interface
Parameters:
- ADDR_W, 12, ROM address / PC width
- NIB_W, 4, ROM data bus width (one nibble)
- MAX_WORDS, 2, max instruction length in words; one word = 2 nibbles
- LEN_W, $clog2(MAX_WORDS+1), width of `inst_len`

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- pc_in  in  ADDR_W  start address, sampled with fetch_start
- inst_len  in  LEN_W  instruction length in words, sampled with fetch_start
- fetch_start  in  1  request a fetch
- fetch_done_ack  in  1  consumer accepted inst_out
- abort  in  1  cancel fetch in progress
- rom_valid  in  1  inst_data_in holds valid nibble this cycle
- inst_data_in  in  NIB_W  ROM nibble
- rom_select  out  1  ROM access active
- pc_out  out  ADDR_W  address of nibble being fetched; next PC when done
- busy  out  1  state != IDLE
- fetch_done  out  1  inst_out valid, held until ack
- len_err  out  1  one-cycle pulse, illegal inst_len rejected
- inst_out  out  2*MAX_WORDS*NIB_W  assembled instruction, left-aligned; first nibble in MSBs; unused LSBs zero

## Operation
- States: IDLE, FETCH, DONE.
- Reset (reset==0 at clock edge, any state): state IDLE, all outputs 0, nibble counter 0.
- IDLE:
  - fetch_start with 1 <= inst_len <= MAX_WORDS: latch pc_in into pc_out; target = 2*inst_len nibbles; counter 0; clear inst_out; go to FETCH.
  - fetch_start with inst_len == 0 or inst_len > MAX_WORDS: stay IDLE; len_err=1 for one cycle; pc_out unchanged.
- FETCH:
  - rom_select=1.
  - Edge with rom_valid=1: inst_data_in written to nibble slot `counter` (slot 0 = MSB nibble); pc_out += 1; counter += 1.
  - Edge with rom_valid=0: no change (wait state).
  - On capturing the final nibble (counter == target-1): go to DONE.
  - fetch_start is ignored in FETCH.
- DONE:
  - rom_select=0, fetch_done=1; pc_out = start PC + target, i.e. the next PC.
  - fetch_done_ack=1: go to IDLE, fetch_done=0.
  - fetch_done_ack and fetch_start in the same cycle with legal length: go directly to FETCH with the new pc_in.
  - fetch_start without ack is ignored.
- abort:
  - In FETCH: has priority over rom_valid. Go to IDLE, clear inst_out, pc_out holds its current value, no fetch_done.
  - In IDLE or DONE: no effect.
- PC arithmetic: modulo 2^ADDR_W; 12'hFFF + 1 wraps to 12'h000 with no flag.
- Priority at each edge: reset > abort > state logic.

## Timing
- fetch_start sampled at edge N. rom_select=1 and pc_out=pc_in are visible after N, so the ROM presents the nibble in cycle N+1.
- Zero wait states: fetch_done rises 2*inst_len cycles after the start edge. One-word fetch: done after edge N+2. Two-word fetch: done after edge N+4.
- Each rom_valid=0 cycle adds exactly one cycle of latency.
- inst_out and pc_out are stable throughout DONE.
- fetch_done falls on the edge where ack is sampled.
- With back-to-back start, rom_select is 0 for exactly one cycle (the DONE cycle).
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- One-word fetch: pc_in=12'hDEA, len=1, nibbles A,5, rom_valid=1.
  - pc_out is DEA, then DEB.
  - fetch_done after 2 cycles; inst_out=16'hA500; pc_out=12'hDEC.
  - After ack: fetch_done=0, busy=0.
- Two-word fetch with wait state: pc_in=12'hABC, len=2, nibbles 3,C,7,E, rom_valid=0 in the cycle after the 2nd nibble.
  - pc_out sequence is ABC, ABD, ABE, ABE, ABF.
  - done after 5 cycles; inst_out=16'h3C7E; pc_out=12'hAC0.
- Wrap-around: pc_in=12'hFFF, len=1, nibbles 1,2 -> pc_out goes FFF then 000; done with inst_out=16'h1200 and pc_out=12'h001.
- Abort: start len=2 at 12'h100, assert abort after 2 nibbles.
  - Next cycle: IDLE, rom_select=0, inst_out=0, no fetch_done pulse.
  - A new fetch at 12'h200 then completes normally.
- Length error and back-to-back:
  - len=0 with fetch_start -> len_err pulse, busy stays 0.
  - len=3 (MAX_WORDS=2) -> len_err pulse.
  - In DONE, assert ack and fetch_start (pc_in=12'h050) in the same cycle -> FETCH next cycle with pc_out=12'h050.
- Reset mid-fetch: reset=0 during FETCH after 1 nibble -> next cycle all outputs 0 and state IDLE; a later fetch_start works normally.

Source files
------------

// File: rtl/nibble_fetcher.sv
// Nibble-serial instruction fetcher: assembles 1..MAX_WORDS two-nibble words from the ROM bus,
// with wait states, abort, length-error reporting and back-to-back fetch on acknowledge.
module nibble_fetcher #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned NIB_W     = 4,
    parameter int unsigned MAX_WORDS = 2,
    parameter int unsigned LEN_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_W-1:0]              pc_in,
    input  logic [LEN_W-1:0]               inst_len,
    input  logic                           fetch_start,
    input  logic                           fetch_done_ack,
    input  logic                           abort,
    input  logic                           rom_valid,
    input  logic [NIB_W-1:0]               inst_data_in,
    output logic                           rom_select,
    output logic [ADDR_W-1:0]              pc_out,
    output logic                           busy,
    output logic                           fetch_done,
    output logic                           len_err,
    output logic [2*MAX_WORDS*NIB_W-1:0]   inst_out
);

    localparam int unsigned NIBS   = 2 * MAX_WORDS;
    localparam int unsigned INST_W = NIBS * NIB_W;
    localparam int unsigned CNT_W  = $clog2(NIBS);

    typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    last_q, last_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                len_err_q, len_err_d;

    logic                len_ok;
    logic [LEN_W:0]      nib_total;
    logic [CNT_W-1:0]    last_start;

    assign len_ok     = (inst_len != '0) && (inst_len <= LEN_W'(MAX_WORDS));
    assign nib_total  = {inst_len, 1'b0};
    // Index of the final nibble slot; only meaningful when len_ok.
    assign last_start = CNT_W'(nib_total - (LEN_W + 1)'(1));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        inst_d    = inst_q;
        len_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fetch_start) begin
                    if (len_ok) begin
                        state_d = StFetch;
                        pc_d    = pc_in;
                        cnt_d   = '0;
                        last_d  = last_start;
                        inst_d  = '0;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            StFetch: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    inst_d  = '0;
                end else if (rom_valid) begin
                    for (int i = 0; i < NIBS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            inst_d[INST_W-1-i*NIB_W -: NIB_W] = inst_data_in;
                        end
                    end
                    pc_d  = pc_q + ADDR_W'(1);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == last_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (fetch_done_ack) begin
                    state_d = StIdle;
                    // Ack together with a legal start chains straight into the next fetch.
                    if (fetch_start) begin
                        if (len_ok) begin
                            state_d = StFetch;
                            pc_d    = pc_in;
                            cnt_d   = '0;
                            last_d  = last_start;
                            inst_d  = '0;
                        end else begin
                            len_err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            cnt_q     <= '0;
            last_q    <= '0;
            inst_q    <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            inst_q    <= inst_d;
            len_err_q <= len_err_d;
        end
    end

    assign rom_select = (state_q == StFetch);
    assign busy       = (state_q != StIdle);
    assign fetch_done = (state_q == StDone);
    assign pc_out     = pc_q;
    assign len_err    = len_err_q;
    assign inst_out   = inst_q;

endmodule

// File: tb/tb_nibble_fetcher.sv
// Self-checking bench for nibble_fetcher: directed scenarios plus randomized fetches
// checked against a transaction-level expectation of PC, latency and assembled instruction.
module tb_nibble_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] pc_in;
    logic [1:0]  inst_len;
    logic        fetch_start;
    logic        fetch_done_ack;
    logic        abort;
    logic        rom_valid;
    logic [3:0]  inst_data_in;
    logic        rom_select;
    logic [11:0] pc_out;
    logic        busy;
    logic        fetch_done;
    logic        len_err;
    logic [15:0] inst_out;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] exp_pc;

    always #5 clk = ~clk;

    nibble_fetcher #(
        .ADDR_W   (12),
        .NIB_W    (4),
        .MAX_WORDS(2),
        .LEN_W    (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc_in),
        .inst_len      (inst_len),
        .fetch_start   (fetch_start),
        .fetch_done_ack(fetch_done_ack),
        .abort         (abort),
        .rom_valid     (rom_valid),
        .inst_data_in  (inst_data_in),
        .rom_select    (rom_select),
        .pc_out        (pc_out),
        .busy          (busy),
        .fetch_done    (fetch_done),
        .len_err       (len_err),
        .inst_out      (inst_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sel"},  32'(rom_select), 0);
        chk({tag, "_pc"},   32'(pc_out), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(fetch_done), 0);
        chk({tag, "_lerr"}, 32'(len_err), 0);
        chk({tag, "_inst"}, 32'(inst_out), 0);
    endtask

    task automatic start(input logic [11:0] pc, input logic [1:0] len);
        pc_in       = pc;
        inst_len    = len;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
    endtask

    // Drive the ROM side of a fetch already in progress; bit c of wmask stalls cycle c.
    task automatic feed(input logic [11:0] pc, input logic [1:0] len, input logic [15:0] nibs,
                        input logic [7:0] wmask);
        int k = 0;
        int cyc = 0;
        int target = 2 * int'(len);
        logic [15:0] exp_inst;
        while (k < target && cyc < target + 8) begin
            chk("fetch_pc", 32'(pc_out), 32'(12'(pc + 12'(k))));
            chk("fetch_sel", 32'(rom_select), 1);
            chk("fetch_nodone", 32'(fetch_done), 0);
            if (cyc < 8 && wmask[cyc]) begin
                rom_valid    = 1'b0;
                inst_data_in = 4'($urandom);
            end else begin
                rom_valid    = 1'b1;
                inst_data_in = nibs[15-4*k -: 4];
            end
            tick();
            if (rom_valid) k++;
            cyc++;
        end
        rom_valid = 1'b0;
        exp_inst  = nibs & (16'hFFFF << (16 - 4 * target));
        exp_pc    = 12'(pc + 12'(target));
        chk("done", 32'(fetch_done), 1);
        chk("done_inst", 32'(inst_out), 32'(exp_inst));
        chk("done_pc", 32'(pc_out), 32'(exp_pc));
        chk("done_sel", 32'(rom_select), 0);
        tick();
        chk("hold_done", 32'(fetch_done), 1);
        chk("hold_inst", 32'(inst_out), 32'(exp_inst));
        chk("hold_pc", 32'(pc_out), 32'(exp_pc));
    endtask

    task automatic ack();
        fetch_done_ack = 1'b1;
        tick();
        fetch_done_ack = 1'b0;
        chk("ack_done", 32'(fetch_done), 0);
        chk("ack_busy", 32'(busy), 0);
    endtask

    task automatic do_fetch(input logic [11:0] pc, input logic [1:0] len, input logic [15:0] nibs,
                            input logic [7:0] wmask);
        start(pc, len);
        feed(pc, len, nibs, wmask);
        ack();
    endtask

    task automatic bad_len(input logic [1:0] len);
        start(12'($urandom), len);
        chk("lerr_pulse", 32'(len_err), 1);
        chk("lerr_busy", 32'(busy), 0);
        chk("lerr_pc", 32'(pc_out), 32'(exp_pc));
        tick();
        chk("lerr_clear", 32'(len_err), 0);
    endtask

    initial begin
        reset          = 1'b0;
        pc_in          = '0;
        inst_len       = '0;
        fetch_start    = 1'b0;
        fetch_done_ack = 1'b0;
        abort          = 1'b0;
        rom_valid      = 1'b0;
        inst_data_in   = '0;
        exp_pc         = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        do_fetch(12'hDEA, 2'd1, 16'hA5FF, 8'h00);
        do_fetch(12'hABC, 2'd2, 16'h3C7E, 8'b0000_0100);
        do_fetch(12'hFFF, 2'd1, 16'h1234, 8'h00);

        // Abort after two nibbles of a two-word fetch.
        start(12'h100, 2'd2);
        for (int i = 0; i < 2; i++) begin
            rom_valid    = 1'b1;
            inst_data_in = 4'($urandom);
            tick();
        end
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        rom_valid = 1'b0;
        exp_pc    = 12'h102;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sel", 32'(rom_select), 0);
        chk("abort_inst", 32'(inst_out), 0);
        chk("abort_done", 32'(fetch_done), 0);
        chk("abort_pc", 32'(pc_out), 32'(exp_pc));
        tick();
        chk("abort_nodone", 32'(fetch_done), 0);
        do_fetch(12'h200, 2'd2, 16'($urandom), 8'h00);

        bad_len(2'd0);
        bad_len(2'd3);

        // Back-to-back: ack and new start sampled together in DONE.
        start(12'h7F0, 2'd1);
        feed(12'h7F0, 2'd1, 16'h9100, 8'h00);
        pc_in          = 12'h050;
        inst_len       = 2'd1;
        fetch_start    = 1'b1;
        fetch_done_ack = 1'b1;
        tick();
        fetch_start    = 1'b0;
        fetch_done_ack = 1'b0;
        chk("b2b_sel", 32'(rom_select), 1);
        chk("b2b_done", 32'(fetch_done), 0);
        feed(12'h050, 2'd1, 16'h6E00, 8'h00);
        ack();

        // Reset in the middle of a fetch.
        start(12'h300, 2'd2);
        rom_valid    = 1'b1;
        inst_data_in = 4'h5;
        tick();
        rom_valid = 1'b0;
        reset     = 1'b0;
        tick();
        reset  = 1'b1;
        exp_pc = '0;
        check_all_zero("midrst");
        bad_len(2'd0);
        do_fetch(12'h3A0, 2'd2, 16'hBEEF, 8'b0000_1001);

        for (int it = 0; it < 30; it++) begin
            logic [1:0]  len;
            logic [11:0] pc;
            len = 2'($urandom_range(0, 3));
            pc  = 12'($urandom);
            if (len == 2'd0 || len == 2'd3) begin
                bad_len(len);
            end else begin
                do_fetch(pc, len, 16'($urandom), 8'($urandom & $urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
